// File: rtl/booth_accumulator.sv
// Block accumulator behind the booth multiplier: sums BLOCK_LEN signed products
// with saturation and hands the block sum downstream over a valid/ready handshake.
module booth_accumulator #(
    parameter int unsigned N         = 4,
    parameter int unsigned ACC_W     = 12,
    parameter int unsigned BLOCK_LEN = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [2*N-1:0]     product_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [ACC_W-1:0]   sum_o,
    output logic               ovf_o,
    output logic [7:0]         count_o
);

    localparam int unsigned PW     = 2 * N;
    localparam int unsigned WIDE_W = ACC_W + 1;
    localparam logic [7:0]  LAST   = 8'(BLOCK_LEN - 1);

    localparam logic signed [ACC_W-1:0] SUM_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SUM_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    if (ACC_W < PW + 1) begin : g_acc_w_check
        $error("booth_accumulator: ACC_W must be at least 2*N+1");
    end
    if (BLOCK_LEN < 1 || BLOCK_LEN > 255) begin : g_block_len_check
        $error("booth_accumulator: BLOCK_LEN must be in 1..255");
    end

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_e;

    state_e                  state_q;
    logic signed [ACC_W-1:0] sum_q;
    logic signed [ACC_W-1:0] sum_d;
    logic [7:0]              count_q;
    logic                    ovf_q;

    logic signed [ACC_W-1:0]  prod_ext_c;
    logic signed [WIDE_W-1:0] wide_c;
    logic                     sat_c;

    // One guard bit above the accumulator; a sign/guard disagreement means overflow.
    always_comb begin
        prod_ext_c = ACC_W'($signed(product_i));
        wide_c     = WIDE_W'(sum_q) + WIDE_W'(prod_ext_c);
        sat_c      = wide_c[ACC_W] ^ wide_c[ACC_W-1];
        sum_d      = wide_c[ACC_W-1:0];
        if (sat_c) begin
            sum_d = wide_c[ACC_W] ? SUM_MIN : SUM_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            state_q <= ST_ACCUM;
            sum_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (in_valid_i) begin
                        sum_q   <= sum_d;
                        count_q <= count_q + 8'd1;
                        ovf_q   <= ovf_q | sat_c;
                        if (count_q == LAST) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // Result held until taken; new block starts only after release.
                    if (out_ready_i) begin
                        state_q <= ST_ACCUM;
                        sum_q   <= '0;
                        count_q <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_ACCUM;
                end
            endcase
        end
    end

    assign in_ready_o  = (state_q == ST_ACCUM);
    assign out_valid_o = (state_q == ST_DONE);
    assign sum_o       = sum_q;
    assign ovf_o       = ovf_q;
    assign count_o     = count_q;

endmodule
